prom_arbiter: RTL and testbench
===============================

PROM_ARBITER -- requirements
Module: prom_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, meaning the program-ROM word address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the program-ROM word width.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 req0_valid / req0_ready  input / output  1 / 1  requester 0 (CPU fetch) read-request handshake.
REQ-006 req0_addr  input  ADDR_W  requester 0 word address.
REQ-007 rsp0_valid / rsp0_ready  output / input  1 / 1  requester 0 response handshake.
REQ-008 rsp0_data  output  DATA_W  requester 0 read data.
REQ-009 req1_*, rsp1_*  same directions and widths as REQ-005..008  requester 1 (debug/LED dump).
REQ-010 rom_ce, rom_oce, rom_reset  output  1 each  ROM clock enable, output enable and reset.
REQ-011 rom_ad  output  ADDR_W  ROM address.
REQ-012 rom_dout  input  DATA_W  ROM read data, valid one clk after the edge that sampled rom_ce=1 and rom_ad; held while rom_ce=0.

Function
REQ-013 A request i SHALL be accepted in a cycle where reqi_valid=1 and reqi_ready=1.
REQ-014 reqi_ready SHALL be 1 only when requester i is eligible and is the arbitration winner in that cycle.
REQ-015 Requester i SHALL be eligible only when all of the following hold:
- inflight_i=0;
- rsp slot i is empty, or rspi_valid=1 and rspi_ready=1 in the same cycle.
REQ-016 When both requesters are valid and eligible, the winner SHALL be the requester not granted most recently (round-robin).
REQ-017 When exactly one requester is valid and eligible, it SHALL win.
REQ-018 last_grant SHALL update only on an accepted request.
REQ-019 In an accept cycle, rom_ce SHALL be 1 and rom_ad SHALL equal the winner's address.
REQ-020 In a non-accept cycle, rom_ce SHALL be 0 and rom_ad SHALL hold its last value.
REQ-021 The block SHALL accept at most one request per cycle.
REQ-022 rom_oce SHALL be constant 1, and rom_reset SHALL equal reset.
REQ-023 inflight_i SHALL be set for exactly the one cycle following acceptance of request i.
REQ-024 While inflight_i=1, rom_dout SHALL be captured into rsp slot i at the end of that cycle.
REQ-025 rspi_valid SHALL rise 2 cycles after the accept edge.
REQ-026 rspi_data SHALL come from a register and SHALL be stable while rspi_valid=1 and rspi_ready=0.
REQ-027 rspi_valid SHALL clear on the cycle after rspi_valid=1 and rspi_ready=1, unless a new capture into slot i occurs in that same cycle.
REQ-028 Response order per requester SHALL equal its request order; responses SHALL never be lost or duplicated.
REQ-029 Throughput: one ROM access per cycle in aggregate; at most one accept every 2 cycles per requester.
REQ-030 A requester whose rspi_ready is held low SHALL NOT block the other requester.

Reset
REQ-031 While reset=1, the block SHALL drive:
- req0_ready=0, req1_ready=0;
- rsp0_valid=0, rsp1_valid=0;
- rsp0_data=0, rsp1_data=0;
- rom_ce=0, rom_ad=0.
REQ-032 While reset=1, the block SHALL clear inflight_0 and inflight_1 and set last_grant=1, so requester 0 wins the first tie.
REQ-033 Reset asserted mid-transaction SHALL discard any in-flight read and any pending responses.
REQ-034 No rspi_valid SHALL be produced after reset for any request accepted before reset.

Structure
REQ-035 Package prom_arb_pkg SHALL hold:
- ADDR_W and DATA_W defaults;
- requester-ID typedef (REQ_CPU=0, REQ_DBG=1);
- response-latency constant (2).
REQ-036 Sub-module prom_rsp_slot SHALL implement one response holding register with its valid/ready handshake, and SHALL be instantiated once per requester.

Verification
REQ-037 Single read: program image loaded, req0 addr 0, then addr 1, rsp0_ready=1 -> rsp0_data=16'h00A1, then 16'h0078, each 2 cycles after its accept.
REQ-038 Tie: both requesters valid every cycle, req0 addr 2, req1 addr 3 -> accepts alternate 0,1,0,1; rsp0_data=16'h0066 and rsp1_data=16'h0091; rom_ce=1 every cycle.
REQ-039 Backpressure: rsp1_ready=0 for 10 cycles after one req1 read of addr 3 -> rsp1_data holds 16'h0091, req1_ready=0 throughout, requester 0 still served each eligible cycle.
REQ-040 Drain-and-refill: rsp0_valid=1 with rsp0_ready=1 in the same cycle as a new req0 -> that request is accepted; no response is dropped.
REQ-041 Reset mid-operation: reset pulsed 1 cycle after a req0 accept -> no rsp0_valid ever appears for it; first post-reset tie goes to requester 0.
REQ-042 Random soak: 10k cycles of random valid/ready on both requesters, checked against a ROM reference model -> data and ordering match, with no loss and no duplication.

Source files
------------

// File: rtl/prom_arb_pkg.sv
// prom_arb_pkg: shared widths, requester IDs and response latency for the program-ROM arbiter
package prom_arb_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int DATA_W_DEF = 16;
  localparam int RSP_LAT = 2;
  typedef enum logic {REQ_CPU = 1'b0, REQ_DBG = 1'b1} req_id_t;
endpackage

// File: rtl/prom_rsp_slot.sv
// prom_rsp_slot: one registered response holding slot with valid/ready handshake
module prom_rsp_slot #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= din;
    end else if (ready) begin
      valid_q <= 1'b0;
    end
  end
  // outputs forced idle during reset, including the first reset cycle
  assign valid = valid_q & ~reset;
  assign data  = reset ? '0 : data_q;
  assign free  = ~valid_q | ready;
endmodule

// File: rtl/prom_arbiter.sv
// prom_arbiter: round-robin arbiter sharing one program ROM between CPU fetch and debug reads
module prom_arbiter
  import prom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic              rom_reset,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout
);
  logic [1:0]        inflight;
  req_id_t           last_grant;
  logic [ADDR_W-1:0] ad_q;
  logic              free0, free1, v0, v1, g0, g1;
  // a slot may be refilled in the same cycle it drains
  assign v0 = req0_valid & ~inflight[0] & free0 & ~reset;
  assign v1 = req1_valid & ~inflight[1] & free1 & ~reset;
  assign g0 = v0 & (~v1 | last_grant == REQ_DBG);
  assign g1 = v1 & ~g0;
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign rom_ce    = g0 | g1;
  assign rom_oce   = 1'b1;
  assign rom_reset = reset;
  assign rom_ad    = reset ? '0 : g0 ? req0_addr : g1 ? req1_addr : ad_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight   <= 2'b00;
      last_grant <= REQ_DBG;
      ad_q       <= '0;
    end else begin
      inflight <= {g1, g0};
      if (rom_ce) begin
        last_grant <= g1 ? REQ_DBG : REQ_CPU;
        ad_q       <= rom_ad;
      end
    end
  end
  prom_rsp_slot #(.DATA_W(DATA_W)) u_slot0 (
    .clk(clk), .reset(reset), .load(inflight[0]), .din(rom_dout),
    .ready(rsp0_ready), .valid(rsp0_valid), .data(rsp0_data), .free(free0)
  );
  prom_rsp_slot #(.DATA_W(DATA_W)) u_slot1 (
    .clk(clk), .reset(reset), .load(inflight[1]), .din(rom_dout),
    .ready(rsp1_ready), .valid(rsp1_valid), .data(rsp1_data), .free(free1)
  );
endmodule

// File: tb/tb_prom_arbiter.sv
// tb_prom_arbiter: directed and random checks of prom_arbiter against a ROM model and scoreboard
module tb_prom_arbiter;
  logic        clk, reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [10:0] req0_addr, req1_addr, rom_ad;
  logic [15:0] rsp0_data, rsp1_data;
  logic [15:0] rom_dout = '0;
  logic        rom_ce, rom_oce, rom_reset;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  prom_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_reset(rom_reset),
    .rom_ad(rom_ad), .rom_dout(rom_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_val(input logic [10:0] a);
    return a == 11'd0 ? 16'h00A1 : a == 11'd1 ? 16'h0078 : a == 11'd2 ? 16'h0066 :
           a == 11'd3 ? 16'h0091 : {a[7:0] ^ 8'h5A, a[7:0]};
  endfunction

  always @(posedge clk) if (rom_ce) rom_dout <= rom_val(rom_ad);

  task automatic sb();
    logic [15:0] e;
    if (reset) begin
      q0.delete();
      q1.delete();
    end else begin
      checks++;
      if (req0_ready && req1_ready) begin
        errors++;
        $display("FAIL one_accept: req0_ready=%b req1_ready=%b, required not both", req0_ready, req1_ready);
      end
      if (req0_valid && req0_ready) q0.push_back(rom_val(req0_addr));
      if (req1_valid && req1_ready) q1.push_back(rom_val(req1_addr));
      if (rsp0_valid && rsp0_ready) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL rsp0_extra: got %h with no outstanding request", rsp0_data);
        end else begin
          e = q0.pop_front();
          if (rsp0_data !== e) begin
            errors++;
            $display("FAIL rsp0_order: got %h required %h", rsp0_data, e);
          end
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL rsp1_extra: got %h with no outstanding request", rsp1_data);
        end else begin
          e = q1.pop_front();
          if (rsp1_data !== e) begin
            errors++;
            $display("FAIL rsp1_order: got %h required %h", rsp1_data, e);
          end
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    sb();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      settle();
      adv();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 11'd7;
    req1_valid = 1'b1; req1_addr = 11'd9;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rom_ce} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl: rdy0/rdy1/v0/v1/ce=%b required 00000",
                 {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rom_ce});
      end
      checks++;
      if (rsp0_data !== 16'h0 || rsp1_data !== 16'h0 || rom_ad !== 11'h0) begin
        errors++;
        $display("FAIL reset_data: d0=%h d1=%h ad=%h required 0", rsp0_data, rsp1_data, rom_ad);
      end
      checks++;
      if (rom_oce !== 1'b1 || rom_reset !== 1'b1) begin
        errors++;
        $display("FAIL reset_rom: oce=%b rom_reset=%b required 1 1", rom_oce, rom_reset);
      end
      adv();
    end
    reset = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_tie();
    logic e0;
    req0_valid = 1'b1; req0_addr = 11'd2;
    req1_valid = 1'b1; req1_addr = 11'd3;
    for (int i = 0; i < 8; i++) begin
      e0 = (i % 2 == 0);
      settle();
      checks++;
      if (req0_ready !== e0 || req1_ready !== !e0) begin
        errors++;
        $display("FAIL tie_grant[%0d]: rdy0=%b rdy1=%b required %b %b", i, req0_ready, req1_ready, e0, !e0);
      end
      checks++;
      if (rom_ce !== 1'b1 || rom_ad !== (e0 ? 11'd2 : 11'd3)) begin
        errors++;
        $display("FAIL tie_rom[%0d]: ce=%b ad=%0d required 1 %0d", i, rom_ce, rom_ad, e0 ? 2 : 3);
      end
      if (i >= 2) begin
        checks++;
        if (rsp0_valid !== e0 || rsp1_valid !== !e0) begin
          errors++;
          $display("FAIL tie_rspv[%0d]: v0=%b v1=%b required %b %b", i, rsp0_valid, rsp1_valid, e0, !e0);
        end
        checks++;
        if (e0 ? rsp0_data !== 16'h0066 : rsp1_data !== 16'h0091) begin
          errors++;
          $display("FAIL tie_data[%0d]: d0=%h d1=%h required 0066 on rsp0 or 0091 on rsp1", i, rsp0_data, rsp1_data);
        end
      end
      adv();
    end
    idle(3);
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 11'd0; rsp0_ready = 1'b1;
    settle();
    checks++;
    if (req0_ready !== 1'b1 || rom_ce !== 1'b1 || rom_ad !== 11'd0) begin
      errors++;
      $display("FAIL single_acc0: rdy=%b ce=%b ad=%0d required 1 1 0", req0_ready, rom_ce, rom_ad);
    end
    adv();
    req0_addr = 11'd1;
    settle();
    checks++;
    if (req0_ready !== 1'b0 || rom_ce !== 1'b0 || rsp0_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_inflight: rdy=%b ce=%b v=%b required 0 0 0", req0_ready, rom_ce, rsp0_valid);
    end
    adv();
    settle();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h00A1) begin
      errors++;
      $display("FAIL single_rsp0: v=%b d=%h required 1 00A1", rsp0_valid, rsp0_data);
    end
    checks++;
    if (req0_ready !== 1'b1 || rom_ad !== 11'd1) begin
      errors++;
      $display("FAIL drain_refill: rdy=%b ad=%0d required 1 1", req0_ready, rom_ad);
    end
    adv();
    req0_valid = 1'b0;
    settle();
    checks++;
    if (rsp0_valid !== 1'b0 || rom_ce !== 1'b0 || rom_ad !== 11'd1) begin
      errors++;
      $display("FAIL single_hold: v=%b ce=%b ad=%0d required 0 0 1", rsp0_valid, rom_ce, rom_ad);
    end
    adv();
    settle();
    checks++;
    if (rsp0_valid !== 1'b1 || rsp0_data !== 16'h0078) begin
      errors++;
      $display("FAIL single_rsp1: v=%b d=%h required 1 0078", rsp0_valid, rsp0_data);
    end
    adv();
    idle(2);
  endtask

  task automatic test_backpressure();
    req1_valid = 1'b1; req1_addr = 11'd3; rsp1_ready = 1'b0;
    req0_valid = 1'b0; req0_addr = 11'd4; rsp0_ready = 1'b1;
    settle();
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_acc1: rdy1=%b required 1", req1_ready);
    end
    adv();
    req0_valid = 1'b1;
    settle();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_acc0: rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
    end
    adv();
    for (int k = 0; k < 10; k++) begin
      settle();
      checks++;
      if (req1_ready !== 1'b0 || rsp1_valid !== 1'b1 || rsp1_data !== 16'h0091) begin
        errors++;
        $display("FAIL bp_hold[%0d]: rdy1=%b v1=%b d1=%h required 0 1 0091", k, req1_ready, rsp1_valid, rsp1_data);
      end
      checks++;
      if (req0_ready !== (k % 2 == 1)) begin
        errors++;
        $display("FAIL bp_req0[%0d]: rdy0=%b required %b", k, req0_ready, k % 2 == 1);
      end
      adv();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp1_ready = 1'b1;
    settle();
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_data !== 16'h0091) begin
      errors++;
      $display("FAIL bp_release: v1=%b d1=%h required 1 0091", rsp1_valid, rsp1_data);
    end
    adv();
    idle(3);
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_addr = 11'd5; req1_valid = 1'b0;
    settle();
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_acc: rdy0=%b required 1", req0_ready);
    end
    adv();
    reset = 1'b1; req0_valid = 1'b0;
    settle();
    adv();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if (rsp0_valid !== 1'b0) begin
        errors++;
        $display("FAIL rmid_stale[%0d]: v0=%b required 0", i, rsp0_valid);
      end
      adv();
    end
    req0_valid = 1'b1; req0_addr = 11'd6;
    req1_valid = 1'b1; req1_addr = 11'd7;
    settle();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rmid_tie: rdy0=%b rdy1=%b required 1 0", req0_ready, req1_ready);
    end
    adv();
    idle(3);
  endtask

  task automatic test_soak();
    for (int i = 0; i < 10000; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_addr  = 11'($urandom_range(0, 2047));
      req1_addr  = 11'($urandom_range(0, 2047));
      rsp0_ready = 1'($urandom_range(0, 1));
      rsp1_ready = 1'($urandom_range(0, 1));
      settle();
      adv();
    end
    idle(6);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL soak_lost: outstanding q0=%0d q1=%0d required 0 0", q0.size(), q1.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = '0; req1_addr = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    test_reset();
    test_tie();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
